// File: rtl/coin_change_engine_pkg.sv
// Shared constants and enums for the coin change engine.
package coin_pkg;
  localparam int NICKEL_C  = 5;
  localparam int DIME_C    = 10;
  localparam int QUARTER_C = 25;
  localparam int DOLLAR_C  = 100;

  typedef enum logic {IDLE, DISPENSE} state_t;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_NICKEL,
    COIN_DIME,
    COIN_QUARTER
  } coin_t;
endpackage

// File: rtl/coin_change_engine_if.sv
// Acceptor/vend/dispense signal bundle of the coin change engine.
interface coin_change_engine_if #(
  parameter int CREDIT_W = 8,
  parameter int N_W      = 4,
  parameter int D_W      = 3,
  parameter int Q_W      = 2
);
  logic                i_nickel;
  logic                i_dime;
  logic                i_quarter;
  logic                i_dollar;
  logic                i_vend;
  logic                i_refund;
  logic [CREDIT_W-1:0] o_credit;
  logic [N_W-1:0]      o_n_cnt;
  logic [D_W-1:0]      o_d_cnt;
  logic [Q_W-1:0]      o_q_cnt;
  logic                o_busy;
  logic                o_nickel_out;
  logic                o_dime_out;
  logic                o_quarter_out;
  logic                o_vend_ok;
  logic                o_vend_denied;
  logic                o_coin_reject;
  logic                o_change_short;

  modport master (
    output i_nickel, i_dime, i_quarter, i_dollar, i_vend, i_refund,
    input  o_credit, o_n_cnt, o_d_cnt, o_q_cnt, o_busy,
           o_nickel_out, o_dime_out, o_quarter_out,
           o_vend_ok, o_vend_denied, o_coin_reject, o_change_short
  );

  modport slave (
    input  i_nickel, i_dime, i_quarter, i_dollar, i_vend, i_refund,
    output o_credit, o_n_cnt, o_d_cnt, o_q_cnt, o_busy,
           o_nickel_out, o_dime_out, o_quarter_out,
           o_vend_ok, o_vend_denied, o_coin_reject, o_change_short
  );
endinterface

// File: rtl/coin_change_engine_tube.sv
// One coin tube: saturating up/down count with full/empty flags.
module coin_tube #(
  parameter  int CAP = 10,
  localparam int W   = $clog2(CAP + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_full  = (r_count == W'(CAP));
  assign o_empty = (r_count == '0);

  // Count update; guards keep the tube from wrapping in either direction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_count <= '0;
    else if (i_inc && !i_dec && !o_full)
      r_count <= r_count + 1'b1;
    else if (i_dec && !i_inc && !o_empty)
      r_count <= r_count - 1'b1;
  end
endmodule

// File: rtl/coin_change_engine.sv
// Coin change engine: credit register, insert acceptance, vend/refund FSM
// and greedy one-coin-per-cycle payout.
//   state    | meaning
//   IDLE     | accepting coins, vend and refund requests
//   DISPENSE | paying out credit greedily, one coin per clock
module coin_change_engine
  import coin_pkg::*;
#(
  parameter int PRICE    = 50,
  parameter int N_CAP    = 10,
  parameter int D_CAP    = 5,
  parameter int Q_CAP    = 3,
  parameter int CREDIT_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  coin_change_engine_if.slave bus
);
  localparam int CREDIT_MAX = 2**CREDIT_W - 1;
  // Headroom for credit plus every coin inserted in one cycle (at most 140).
  localparam int SUM_W = CREDIT_W + 8;
  localparam int N_W = $clog2(N_CAP + 1);
  localparam int D_W = $clog2(D_CAP + 1);
  localparam int Q_W = $clog2(Q_CAP + 1);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_busy, r_n_out, r_d_out, r_q_out;
  logic                r_vend_ok, r_vend_denied, r_coin_reject, r_change_short;

  logic            w_n_full, w_d_full, w_q_full;
  logic            w_n_empty, w_d_empty, w_q_empty;
  logic [N_W-1:0]  w_n_cnt;
  logic [D_W-1:0]  w_d_cnt;
  logic [Q_W-1:0]  w_q_cnt;
  logic [SUM_W-1:0] w_sum, w_credit_ext;
  logic            w_acc_n, w_acc_d, w_acc_q, w_acc_dl;
  logic            w_any_ins, w_any_rej;
  coin_t           w_pick;

  assign w_credit_ext = SUM_W'(r_credit);
  assign w_any_ins = bus.i_nickel | bus.i_dime | bus.i_quarter | bus.i_dollar;

  coin_tube #(.CAP(N_CAP)) u_n_tube (
    .i_clk(i_clock), .i_rst(i_reset),
    .i_inc(w_acc_n), .i_dec(r_state == DISPENSE && w_pick == COIN_NICKEL),
    .o_count(w_n_cnt), .o_full(w_n_full), .o_empty(w_n_empty));

  coin_tube #(.CAP(D_CAP)) u_d_tube (
    .i_clk(i_clock), .i_rst(i_reset),
    .i_inc(w_acc_d), .i_dec(r_state == DISPENSE && w_pick == COIN_DIME),
    .o_count(w_d_cnt), .o_full(w_d_full), .o_empty(w_d_empty));

  coin_tube #(.CAP(Q_CAP)) u_q_tube (
    .i_clk(i_clock), .i_rst(i_reset),
    .i_inc(w_acc_q), .i_dec(r_state == DISPENSE && w_pick == COIN_QUARTER),
    .o_count(w_q_cnt), .o_full(w_q_full), .o_empty(w_q_empty));

  // Acceptance: running sum in order dollar, quarter, dime, nickel; only in IDLE.
  always_comb begin
    w_sum    = w_credit_ext;
    w_acc_dl = 1'b0;
    w_acc_q  = 1'b0;
    w_acc_d  = 1'b0;
    w_acc_n  = 1'b0;
    if (r_state == IDLE) begin
      if (bus.i_dollar && (w_sum + SUM_W'(DOLLAR_C) <= SUM_W'(CREDIT_MAX))) begin
        w_acc_dl = 1'b1;
        w_sum    = w_sum + SUM_W'(DOLLAR_C);
      end
      if (bus.i_quarter && !w_q_full && (w_sum + SUM_W'(QUARTER_C) <= SUM_W'(CREDIT_MAX))) begin
        w_acc_q = 1'b1;
        w_sum   = w_sum + SUM_W'(QUARTER_C);
      end
      if (bus.i_dime && !w_d_full && (w_sum + SUM_W'(DIME_C) <= SUM_W'(CREDIT_MAX))) begin
        w_acc_d = 1'b1;
        w_sum   = w_sum + SUM_W'(DIME_C);
      end
      if (bus.i_nickel && !w_n_full && (w_sum + SUM_W'(NICKEL_C) <= SUM_W'(CREDIT_MAX))) begin
        w_acc_n = 1'b1;
        w_sum   = w_sum + SUM_W'(NICKEL_C);
      end
    end
    w_any_rej = (bus.i_dollar & ~w_acc_dl) | (bus.i_quarter & ~w_acc_q) |
                (bus.i_dime & ~w_acc_d) | (bus.i_nickel & ~w_acc_n);
  end

  // Greedy payout selection from the remaining credit and stocked tubes.
  always_comb begin
    w_pick = COIN_NONE;
    if (w_credit_ext >= SUM_W'(QUARTER_C) && !w_q_empty)
      w_pick = COIN_QUARTER;
    else if (w_credit_ext >= SUM_W'(DIME_C) && !w_d_empty)
      w_pick = COIN_DIME;
    else if (w_credit_ext >= SUM_W'(NICKEL_C) && !w_n_empty)
      w_pick = COIN_NICKEL;
  end

  // Control FSM with credit register and registered pulse outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_busy         <= 1'b0;
      r_n_out        <= 1'b0;
      r_d_out        <= 1'b0;
      r_q_out        <= 1'b0;
      r_vend_ok      <= 1'b0;
      r_vend_denied  <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_change_short <= 1'b0;
    end else begin
      r_n_out        <= 1'b0;
      r_d_out        <= 1'b0;
      r_q_out        <= 1'b0;
      r_vend_ok      <= 1'b0;
      r_vend_denied  <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_change_short <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_ins) begin
            r_credit      <= CREDIT_W'(w_sum);
            r_coin_reject <= w_any_rej;
          end else if (bus.i_refund) begin
            r_state <= DISPENSE;
            r_busy  <= 1'b1;
          end else if (bus.i_vend) begin
            if (w_credit_ext >= SUM_W'(PRICE)) begin
              r_credit  <= r_credit - CREDIT_W'(PRICE);
              r_vend_ok <= 1'b1;
              r_state   <= DISPENSE;
              r_busy    <= 1'b1;
            end else begin
              r_vend_denied <= 1'b1;
            end
          end
        end
        DISPENSE: begin
          // Vend/refund are dropped here; inserts are bounced.
          r_coin_reject <= w_any_ins;
          case (w_pick)
            COIN_QUARTER: begin
              r_credit <= r_credit - CREDIT_W'(QUARTER_C);
              r_q_out  <= 1'b1;
            end
            COIN_DIME: begin
              r_credit <= r_credit - CREDIT_W'(DIME_C);
              r_d_out  <= 1'b1;
            end
            COIN_NICKEL: begin
              r_credit <= r_credit - CREDIT_W'(NICKEL_C);
              r_n_out  <= 1'b1;
            end
            default: begin
              r_state        <= IDLE;
              r_busy         <= 1'b0;
              r_change_short <= (r_credit != '0);
            end
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_credit       = r_credit;
  assign bus.o_n_cnt        = w_n_cnt;
  assign bus.o_d_cnt        = w_d_cnt;
  assign bus.o_q_cnt        = w_q_cnt;
  assign bus.o_busy         = r_busy;
  assign bus.o_nickel_out   = r_n_out;
  assign bus.o_dime_out     = r_d_out;
  assign bus.o_quarter_out  = r_q_out;
  assign bus.o_vend_ok      = r_vend_ok;
  assign bus.o_vend_denied  = r_vend_denied;
  assign bus.o_coin_reject  = r_coin_reject;
  assign bus.o_change_short = r_change_short;
endmodule
